// File: rtl/mem_burst_ctrl.sv
// -----------------------------------------------------------------------------
// mem_burst_ctrl
//
// Burst controller that turns one {write, addr, len} command into a run of
// single-byte accesses on a simple synchronous memory port.
//   * Write bursts consume one byte per wr_valid&&wr_ready. They may stall.
//   * Read bursts issue one address per cycle without stalls. Returned data
//     is flagged with rd_valid a fixed LAT cycles later.
//
// Parameter
//   RD_MODE    0: direct-address memory, LAT = 1.
//              1: registered-address memory, LAT = 2. Reported on mem_mode.
//
// Build option
//   MEM_BURST_CTRL_WRAP_EN  defined  : bursts that run past address 31 wrap to 0.
//                           undefined: such commands are dropped in IDLE with a
//                                      one-cycle err pulse.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_write           1 = write burst, 0 = read burst
//   cmd_addr, cmd_len   start address, beats minus one
//   wr_valid/ready      write byte handshake (ready only while writing)
//   wr_data             write byte
//   rd_valid, rd_data   read return, no backpressure
//   busy, done, err     status: not idle / burst finished / command rejected
//   mem_we, mem_addr,
//   mem_din, mem_mode   memory request port
//   mem_q               memory read data
// -----------------------------------------------------------------------------
module mem_burst_ctrl #(
    parameter int RD_MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [4:0] cmd_addr,
    input  logic [4:0] cmd_len,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       mem_we,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_mode,
    input  logic [7:0] mem_q
);

    localparam int LAT = (RD_MODE != 0) ? 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t         state_q;
    logic [4:0]     addr_q;
    logic [4:0]     cnt_q;
    logic [4:0]     last_addr_q;
    logic [LAT-1:0] pipe_q;
    logic [LAT-1:0] pipe_d;
    logic           err_q;
    logic           issue;
    logic           range_bad;

`ifdef MEM_BURST_CTRL_WRAP_EN
    // Address arithmetic simply rolls over; no command is ever refused.
    assign range_bad = 1'b0;
`else
    // A carry out of the 5-bit end address means the burst would cross 31.
    logic [5:0] end_addr;
    assign end_addr  = {1'b0, cmd_addr} + {1'b0, cmd_len};
    assign range_bad = end_addr[5];
`endif

    // Every RD cycle puts exactly one address on the memory port.
    assign issue = (state_q == S_RD);

    // Read-return tracker: one token per issued address, shifted once per
    // cycle; the token falls out of the top stage when mem_q holds its data.
    for (genvar gi = 0; gi < LAT; gi++) begin : g_pipe
        if (gi == 0) begin : g_head
            assign pipe_d[gi] = issue;
        end else begin : g_tail
            assign pipe_d[gi] = pipe_q[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            last_addr_q <= '0;
            pipe_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            pipe_q <= pipe_d;
            err_q  <= 1'b0;

            // Remember what was last driven so mem_addr is stable when idle.
            if (state_q == S_WR || state_q == S_RD) begin
                last_addr_q <= addr_q;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (range_bad) begin
                            // Command consumed without starting a burst.
                            err_q <= 1'b1;
                        end else begin
                            addr_q  <= cmd_addr;
                            cnt_q   <= cmd_len;
                            state_q <= cmd_write ? S_WR : S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (wr_valid) begin
                        addr_q <= addr_q + 5'd1;
                        cnt_q  <= cnt_q - 5'd1;
                        if (cnt_q == 5'd0) begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_RD: begin
                    addr_q <= addr_q + 5'd1;
                    cnt_q  <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave once nothing is left in flight after this cycle,
                    // so FIN lands right after the final rd_valid.
                    if (pipe_d == '0) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = (state_q == S_WR);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign err       = err_q;

    assign rd_valid  = pipe_q[LAT-1];
    assign rd_data   = pipe_q[LAT-1] ? mem_q : 8'h00;

    assign mem_we    = (state_q == S_WR) && wr_valid;
    assign mem_addr  = (state_q == S_WR || state_q == S_RD) ? addr_q : last_addr_q;
    assign mem_din   = wr_data;
    assign mem_mode  = (RD_MODE != 0);

endmodule
